// File: rtl/snake_pkg.sv
// Shared definitions for the snake game input path: one-hot movement
// directions, the opposite-direction helper and the default debounce length.
package snake_pkg;

   typedef logic [3:0] dir_t;

   localparam dir_t DIR_NONE  = 4'b0000;
   localparam dir_t DIR_UP    = 4'b0001;
   localparam dir_t DIR_LEFT  = 4'b0010;
   localparam dir_t DIR_DOWN  = 4'b0100;
   localparam dir_t DIR_RIGHT = 4'b1000;

   localparam int DEBOUNCE_DEFAULT = 4;

   // Opposite of a one-hot direction; anything else maps to DIR_NONE.
   function automatic dir_t dir_oposta(input dir_t d);
      case (d)
         DIR_UP:    return DIR_DOWN;
         DIR_DOWN:  return DIR_UP;
         DIR_LEFT:  return DIR_RIGHT;
         DIR_RIGHT: return DIR_LEFT;
         default:   return DIR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/inputs_botao_if.sv
// Button/direction bundle between the board buttons and the game core.
// master drives the raw buttons, slave (inputs_botao) returns the direction.
interface inputs_botao_if;
   import snake_pkg::*;

   logic w;
   logic a;
   logic s;
   logic d;
   dir_t direcao;
   logic mudou;

   modport master (output w, a, s, d, input direcao, mudou);
   modport slave  (input w, a, s, d, output direcao, mudou);

endinterface

// File: rtl/inputs_botao_debouncer.sv
// One button: two-flop synchronizer followed by a symmetric counter debouncer.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles of
// disagreement with the synchronized level.
module inputs_botao_debouncer
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Synchronize, then count cycles of disagreement; toggle on the last one.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] != level) begin
            if (cnt == CNT_LAST) begin
               level <= ~level;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/inputs_botao.sv
// Four debounced buttons (w/a/s/d) to a registered one-hot direction.
// A debounced rising edge requests a direction; fixed priority w > a > s > d.
// Build option REVERSAL_BLOCK_EN: requests for the exact opposite of the
// current direction are dropped before priority selection.
module inputs_botao
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input logic           clock,
   input logic           reset,
   inputs_botao_if.slave bus
);

   localparam int NUM_BTN = 4;

   // Bit i of each vector lines up with the one-hot direction bit it requests.
   logic [NUM_BTN-1:0] btn;
   logic [NUM_BTN-1:0] deb;
   logic [NUM_BTN-1:0] deb_prev;
   logic [NUM_BTN-1:0] req;
   logic [NUM_BTN-1:0] cand;
   dir_t               prox;
   dir_t               direcao_q;
   logic               mudou_q;

   assign btn = {bus.d, bus.s, bus.a, bus.w};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      inputs_botao_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clock (clock),
         .reset (reset),
         .raw   (btn[i]),
         .level (deb[i])
      );
   end

   assign req = deb & ~deb_prev;

   // Filter reversals (optional), then pick the highest-priority request.
   always_comb begin
      cand = req;
`ifdef REVERSAL_BLOCK_EN
      if (direcao_q != DIR_NONE)
         cand = req & ~dir_oposta(direcao_q);
`endif
      prox = DIR_NONE;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (cand[i]) begin
            prox    = DIR_NONE;
            prox[i] = 1'b1;
         end
      end
   end

   // Edge history and registered direction; mudou pulses on a real change.
   always_ff @(posedge clock) begin
      if (reset) begin
         deb_prev  <= '0;
         direcao_q <= DIR_NONE;
         mudou_q   <= 1'b0;
      end else begin
         deb_prev <= deb;
         mudou_q  <= 1'b0;
         if (prox != DIR_NONE && prox != direcao_q) begin
            direcao_q <= prox;
            mudou_q   <= 1'b1;
         end
      end
   end

   assign bus.direcao = direcao_q;
   assign bus.mudou   = mudou_q;

endmodule

// File: tb/tb_inputs_botao.sv
// Directed bench for inputs_botao with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_inputs_botao;
   import snake_pkg::*;

   logic clock;
   logic reset;
   int   tests;
   int   failed;
   int   npulse;

   inputs_botao_if bus ();

   inputs_botao #(.DEBOUNCE_CYCLES(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance n edges, counting mudou pulses seen.
   task automatic run(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
         if (bus.mudou === 1'b1) npulse++;
      end
   endtask

   // Press a set of buttons {d,s,a,w}, wait for acceptance, release, settle.
   task automatic tap(input logic [3:0] b);
      {bus.d, bus.s, bus.a, bus.w} = b;
      run(10);
      {bus.d, bus.s, bus.a, bus.w} = 4'b0000;
      run(10);
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      npulse = 0;
      reset  = 1'b1;
      {bus.d, bus.s, bus.a, bus.w} = 4'b0000;
      run(2);
      chk("reset_dir", bus.direcao, DIR_NONE);
      chk("reset_mudou", {3'b0, bus.mudou}, 4'b0);
      reset = 1'b0;

      // Idle: stays stopped.
      npulse = 0;
      for (int i = 0; i < 10; i++) begin
         run(1);
         chk("idle_dir", bus.direcao, DIR_NONE);
      end
      chk("idle_pulses", 4'(npulse), 4'd0);

      // w raised before edge k: debounced at k+5, direction at k+6.
      bus.w = 1'b1;
      run(6);
      chk("w_k5_dir", bus.direcao, DIR_NONE);
      chk("w_k5_mudou", {3'b0, bus.mudou}, 4'b0);
      run(1);
      chk("w_k6_dir", bus.direcao, DIR_UP);
      chk("w_k6_mudou", {3'b0, bus.mudou}, 4'b1);
      run(1);
      chk("w_k7_mudou", {3'b0, bus.mudou}, 4'b0);
      bus.w = 1'b0;
      npulse = 0;
      run(10);
      chk("w_release_dir", bus.direcao, DIR_UP);
      chk("w_release_pulses", 4'(npulse), 4'd0);

      // 3-cycle glitch on d is filtered.
      bus.d = 1'b1;
      run(3);
      bus.d = 1'b0;
      run(12);
      chk("d_glitch_dir", bus.direcao, DIR_UP);
      chk("d_glitch_pulses", 4'(npulse), 4'd0);

      // 6-cycle d pulse is accepted.
      bus.d = 1'b1;
      run(6);
      bus.d = 1'b0;
      run(14);
      chk("d_pulse_dir", bus.direcao, DIR_RIGHT);
      chk("d_pulse_pulses", 4'(npulse), 4'd1);

      // Back to up, then a and s together: a wins.
      tap(4'b0001);
      chk("to_up_dir", bus.direcao, DIR_UP);
      npulse = 0;
      tap(4'b0110);
      chk("as_dir", bus.direcao, DIR_LEFT);
      chk("as_pulses", 4'(npulse), 4'd1);

      // Same-direction request: no change, no pulse.
      npulse = 0;
      tap(4'b0010);
      chk("same_dir", bus.direcao, DIR_LEFT);
      chk("same_pulses", 4'(npulse), 4'd0);

      // Right, then the reversal left.
      tap(4'b0001);
      tap(4'b1000);
      chk("to_right_dir", bus.direcao, DIR_RIGHT);
      npulse = 0;
      tap(4'b0010);
`ifdef REVERSAL_BLOCK_EN
      chk("rev_a_dir", bus.direcao, DIR_RIGHT);
      chk("rev_a_pulses", 4'(npulse), 4'd0);
`else
      chk("rev_a_dir", bus.direcao, DIR_LEFT);
      chk("rev_a_pulses", 4'(npulse), 4'd1);
`endif
      tap(4'b0001);
      chk("rev_w_dir", bus.direcao, DIR_UP);

      // From up, s and d together: s is a reversal when blocking is on.
      npulse = 0;
      tap(4'b1100);
`ifdef REVERSAL_BLOCK_EN
      chk("sd_dir", bus.direcao, DIR_RIGHT);
`else
      chk("sd_dir", bus.direcao, DIR_DOWN);
`endif
      chk("sd_pulses", 4'(npulse), 4'd1);

      // Get to down and keep s held through a one-cycle reset.
      bus.s = 1'b1;
      run(10);
      chk("s_held_dir", bus.direcao, DIR_DOWN);
      reset = 1'b1;
      run(1);
      chk("rst_s_dir", bus.direcao, DIR_NONE);
      chk("rst_s_mudou", {3'b0, bus.mudou}, 4'b0);
      reset = 1'b0;
      // Held s is re-synchronized from the first edge after reset (edge k),
      // so the direction returns at k+6.
      run(6);
      chk("post_rst_k5_dir", bus.direcao, DIR_NONE);
      run(1);
      chk("post_rst_k6_dir", bus.direcao, DIR_DOWN);
      chk("post_rst_k6_mudou", {3'b0, bus.mudou}, 4'b1);
      run(1);
      chk("post_rst_k7_mudou", {3'b0, bus.mudou}, 4'b0);
      npulse = 0;
      run(10);
      chk("s_hold_no_retrigger", 4'(npulse), 4'd0);
      bus.s = 1'b0;
      run(10);
      chk("final_dir", bus.direcao, DIR_DOWN);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
